// File: rtl/uart_pkg.sv
// uart_pkg: register offsets, STATUS bit positions, FSM state types and the
// bit-period divider helper shared by the uart_mmio slice.
package uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int unsigned ST_RX_AVAIL  = 0;
  localparam int unsigned ST_TX_BUSY   = 1;
  localparam int unsigned ST_OVERRUN   = 2;
  localparam int unsigned ST_FRAME_ERR = 3;

  typedef enum logic [1:0] {BUS_IDLE, BUS_ACK, BUS_WAIT_REL} bus_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Clock cycles per serial bit, truncated.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO with power-of-two depth. Pointers carry one
// extra wrap bit to tell full from empty. A push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointer update; wrap is implicit in the power-of-two width.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART. Bus handshake FSM, TX with one-byte
// holding register, RX with 2-FF synchroniser feeding uart_rx_fifo.
// Optional macro UART_LOOPBACK_EN adds CTRL bit0 (internal txd -> rx loopback).
module uart_mmio
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ_HZ = 50000000,
  parameter int unsigned BAUD          = 115200,
  parameter int unsigned RX_DEPTH      = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ctrl_wr,
  input  logic        ctrl_rd,
  input  logic [31:0] ctrl_addr,
  input  logic [31:0] ctrl_wdat,
  output logic [31:0] ctrl_rdat,
  output logic        ctrl_done,
  input  logic        rxd,
  output logic        txd
);

  localparam int unsigned DIV = calc_div(CLOCK_FREQ_HZ, BAUD);
  localparam int unsigned CW  = $clog2(DIV);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

  // ---------------- bus side ----------------
  bus_state_t  bus_state, bus_next;
  logic        req, wr_stall, do_ack;
  logic        op_wr, op_pop;
  logic [1:0]  op_addr;
  logic [7:0]  op_wdat;
  logic [31:0] rd_value, rdat_q;
  logic        hold_full;
  logic [7:0]  hold_data;
  logic        overrun, frame_err;
  logic        fifo_full, fifo_empty, fifo_pop;
  logic [7:0]  fifo_head;
  logic        tx_busy;
  logic        unused_bits;

  assign unused_bits = ^{ctrl_addr[31:4], ctrl_addr[1:0], ctrl_wdat[31:8]};

  assign req       = ctrl_wr || ctrl_rd;
  assign wr_stall  = ctrl_wr && (ctrl_addr[3:2] == REG_DATA) && hold_full;
  assign do_ack    = (bus_state == BUS_ACK);
  assign ctrl_done = do_ack;
  assign ctrl_rdat = rdat_q;
  assign fifo_pop  = do_ack && op_pop;

`ifdef UART_LOOPBACK_EN
  logic loopback;
`endif

  // Read mux for the address currently presented on the bus.
  always_comb begin
    rd_value = '0;
    case (ctrl_addr[3:2])
      REG_DATA:   rd_value = fifo_empty ? '1 : {24'b0, fifo_head};
      REG_STATUS: rd_value = {28'b0, frame_err, overrun, tx_busy, !fifo_empty};
`ifdef UART_LOOPBACK_EN
      REG_CTRL:   rd_value = {31'b0, loopback};
`endif
      default:    rd_value = '0;
    endcase
  end

  // Bus next state: a DATA write waits in IDLE while the holding register is full.
  always_comb begin
    bus_next = bus_state;
    case (bus_state)
      BUS_IDLE:     if (req && !wr_stall) bus_next = BUS_ACK;
      BUS_ACK:      bus_next = BUS_WAIT_REL;
      BUS_WAIT_REL: if (!req) bus_next = BUS_IDLE;
      default:      bus_next = BUS_IDLE;
    endcase
  end

  // Bus state register; the request is captured when it is accepted so side
  // effects and read data are settled for the single done cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bus_state <= BUS_IDLE;
      op_wr     <= 1'b0;
      op_pop    <= 1'b0;
      op_addr   <= '0;
      op_wdat   <= '0;
      rdat_q    <= '0;
    end else begin
      bus_state <= bus_next;
      if (bus_state == BUS_IDLE && bus_next == BUS_ACK) begin
        op_wr   <= ctrl_wr;
        op_addr <= ctrl_addr[3:2];
        op_wdat <= ctrl_wdat[7:0];
        op_pop  <= !ctrl_wr && (ctrl_addr[3:2] == REG_DATA) && !fifo_empty;
        rdat_q  <= ctrl_wr ? '0 : rd_value;
      end
    end
  end

  // ---------------- TX ----------------
  tx_state_t     tx_state, tx_next;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          tx_tick;

  assign tx_tick = (tx_cnt == '0);
  assign tx_busy = hold_full || (tx_state != TX_IDLE);

  // Holding register: filled by the bus in its done cycle, drained by TX in IDLE.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else if (do_ack && op_wr && op_addr == REG_DATA) begin
      hold_full <= 1'b1;
      hold_data <= op_wdat;
    end else if (tx_state == TX_IDLE && hold_full) begin
      hold_full <= 1'b0;
    end
  end

  // TX next state and line level.
  always_comb begin
    tx_next = tx_state;
    txd     = 1'b1;
    case (tx_state)
      TX_IDLE:  if (hold_full) tx_next = TX_START;
      TX_START: begin
        txd = 1'b0;
        if (tx_tick) tx_next = TX_DATA;
      end
      TX_DATA: begin
        txd = tx_shift[0];
        if (tx_tick && tx_bit == 3'd7) tx_next = TX_STOP;
      end
      TX_STOP:  if (tx_tick) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  // TX state, bit-period down-counter and LSB-first shifter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      tx_state <= tx_next;
      if (tx_state == TX_IDLE) begin
        if (hold_full) begin
          tx_shift <= hold_data;
          tx_cnt   <= BIT_LAST;
          tx_bit   <= '0;
        end
      end else if (tx_tick) begin
        tx_cnt <= BIT_LAST;
        if (tx_state == TX_DATA) begin
          tx_shift <= {1'b0, tx_shift[7:1]};
          tx_bit   <= tx_bit + 3'd1;
        end
      end else begin
        tx_cnt <= tx_cnt - 1'b1;
      end
    end
  end

  // ---------------- RX ----------------
  rx_state_t     rx_state, rx_next;
  logic          rx_src, rx_s1, rx_s2, rx_prev;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_tick, rx_fall, rx_push, rx_ferr;

`ifdef UART_LOOPBACK_EN
  assign rx_src = loopback ? txd : rxd;
`else
  assign rx_src = rxd;
`endif

  assign rx_tick = (rx_cnt == '0);
  assign rx_fall = rx_prev && !rx_s2;
  assign rx_push = (rx_state == RX_STOP) && rx_tick && rx_s2;
  assign rx_ferr = (rx_state == RX_STOP) && rx_tick && !rx_s2;

  // Two-stage synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx_src;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // RX next state: a start bit that is high again at mid-bit is a glitch.
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_next = RX_START;
      RX_START: if (rx_tick) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (rx_tick) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  // RX state, sample counter (half period first, then full) and shifter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_next;
      if (rx_state == RX_IDLE) begin
        if (rx_fall) rx_cnt <= HALF_LAST;
      end else if (rx_tick) begin
        rx_cnt <= BIT_LAST;
        if (rx_state == RX_START) rx_bit <= '0;
        if (rx_state == RX_DATA) begin
          rx_shift <= {rx_s2, rx_shift[7:1]};
          rx_bit   <= rx_bit + 3'd1;
        end
      end else begin
        rx_cnt <= rx_cnt - 1'b1;
      end
    end
  end

  uart_rx_fifo #(
    .DEPTH (RX_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (rx_push),
    .din    (rx_shift),
    .pop    (fifo_pop),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (fifo_head)
  );

  // Sticky flags; a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (rx_push && fifo_full && !fifo_pop)
        overrun <= 1'b1;
      else if (do_ack && op_wr && op_addr == REG_STATUS && op_wdat[ST_OVERRUN])
        overrun <= 1'b0;
      if (rx_ferr)
        frame_err <= 1'b1;
      else if (do_ack && op_wr && op_addr == REG_STATUS && op_wdat[ST_FRAME_ERR])
        frame_err <= 1'b0;
    end
  end

`ifdef UART_LOOPBACK_EN
  // CTRL register: bit0 routes txd back into the receiver.
  always_ff @(posedge clk) begin
    if (!resetn)
      loopback <= 1'b0;
    else if (do_ack && op_wr && op_addr == REG_CTRL)
      loopback <= op_wdat[0];
  end
`endif

endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: directed self-checking bench for uart_mmio with DIV = 8.
module tb_uart_mmio;

  localparam int DIV = 8;
  localparam logic [1:0] A_DATA = 2'd0, A_STATUS = 2'd1, A_CTRL = 2'd2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ctrl_wr, ctrl_rd;
  logic [31:0] ctrl_addr, ctrl_wdat, ctrl_rdat;
  logic        ctrl_done;
  logic        rxd, txd;

  int tests = 0;
  int fails = 0;
  logic [7:0] mon_q [$];

  uart_mmio #(
    .CLOCK_FREQ_HZ (800),
    .BAUD          (100),
    .RX_DEPTH      (16)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .ctrl_wr   (ctrl_wr),
    .ctrl_rd   (ctrl_rd),
    .ctrl_addr (ctrl_addr),
    .ctrl_wdat (ctrl_wdat),
    .ctrl_rdat (ctrl_rdat),
    .ctrl_done (ctrl_done),
    .rxd       (rxd),
    .txd       (txd)
  );

  always #5 clk = ~clk;

  // Line monitor: decodes each txd frame at mid-bit into mon_q.
  always begin
    logic [7:0] b;
    @(negedge txd);
    repeat (DIV / 2) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (DIV) @(posedge clk);
      b[i] = txd;
    end
    repeat (DIV) @(posedge clk);
    mon_q.push_back(b);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_op(input logic wr, input logic [1:0] a, input logic [31:0] wd,
                        input int hold, output logic [31:0] rd, output int cyc);
    tick(2);
    ctrl_wr   = wr;
    ctrl_rd   = !wr;
    ctrl_addr = {28'h0, a, 2'b00};
    ctrl_wdat = wd;
    cyc = 0;
    while (ctrl_done !== 1'b1 && cyc < 2000) begin
      tick(1);
      cyc++;
    end
    rd = ctrl_rdat;
    chk("bus_done_seen", 32'(ctrl_done), 32'd1);
    if (hold > 0) begin
      tick(1);
      chk("done_one_cycle", 32'(ctrl_done), 32'd0);
      tick(hold - 1);
    end
    ctrl_wr = 1'b0;
    ctrl_rd = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(DIV);
    end
    rxd = stop;
    tick(DIV);
    rxd = 1'b1;
    tick(4);
  endtask

  initial begin
    logic [31:0] rd;
    int c1, c2, c3, n;
    logic [7:0] exp;

    resetn = 1'b0; ctrl_wr = 1'b0; ctrl_rd = 1'b0;
    ctrl_addr = '0; ctrl_wdat = '0; rxd = 1'b1;
    tick(3);
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_done", 32'(ctrl_done), 32'd0);
    chk("rst_rdat", ctrl_rdat, 32'h0);
    resetn = 1'b1;
    bus_op(1'b0, A_STATUS, '0, 0, rd, c1);
    chk("rst_status", rd, 32'h0);

    // TX timing for 0x55
    bus_op(1'b1, A_DATA, 32'h55, 0, rd, c1);
    chk("tx_done_latency", 32'(c1), 32'd1);
    n = 0;
    while (txd !== 1'b0 && n < 50) begin tick(1); n++; end
    chk("tx_start_seen", 32'(txd), 32'd0);
    tick(7);
    chk("tx_start_last", 32'(txd), 32'd0);
    tick(1);
    chk("tx_bit0_edge", 32'(txd), 32'd1);
    tick(4);
    exp = 8'h55;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("tx_bit%0d", k), 32'(txd), 32'(exp[k]));
      tick(DIV);
    end
    chk("tx_stop", 32'(txd), 32'd1);
    tick(DIV);
    chk("mon_55", 32'(mon_q.size() > 0 ? mon_q[0] : 8'hxx), 32'h55);
    mon_q.delete();

    // Back-pressure: third write stalls until byte 1 is on the wire
    bus_op(1'b1, A_DATA, 32'h01, 0, rd, c1);
    bus_op(1'b1, A_DATA, 32'h02, 0, rd, c2);
    bus_op(1'b1, A_DATA, 32'h03, 0, rd, c3);
    chk("bp_first", 32'(c1), 32'd1);
    chk("bp_second", 32'(c2), 32'd1);
    chk("bp_third_stalled", 32'(c3 >= 60), 32'd1);
    n = 0;
    while (mon_q.size() < 3 && n < 2000) begin tick(1); n++; end
    chk("bp_count", 32'(mon_q.size()), 32'd3);
    for (int k = 0; k < 3; k++)
      chk($sformatf("bp_byte%0d", k), 32'(k < mon_q.size() ? mon_q[k] : 8'hxx), 32'(k + 1));
    tick(2 * DIV);

    // RX and empty read
    send_frame(8'hA3, 1'b1);
    bus_op(1'b0, A_STATUS, '0, 0, rd, c1);
    chk("rx_status", rd, 32'h1);
    bus_op(1'b0, A_DATA, '0, 0, rd, c1);
    chk("rx_data", rd, 32'h0000_00A3);
    chk("rx_data_latency", 32'(c1), 32'd1);
    bus_op(1'b0, A_DATA, '0, 0, rd, c1);
    chk("rx_empty", rd, 32'hFFFF_FFFF);
    chk("rx_empty_latency", 32'(c1), 32'd1);

    // Held request pops once
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    bus_op(1'b0, A_DATA, '0, 2, rd, c1);
    chk("held_first", rd, 32'h11);
    bus_op(1'b0, A_DATA, '0, 0, rd, c1);
    chk("held_second", rd, 32'h22);
    bus_op(1'b0, A_DATA, '0, 0, rd, c1);
    chk("held_empty", rd, 32'hFFFF_FFFF);

    // Overrun: 17 frames into a 16-deep FIFO
    for (int i = 1; i <= 17; i++) send_frame(8'(i), 1'b1);
    bus_op(1'b0, A_STATUS, '0, 0, rd, c1);
    chk("ovr_status", rd, 32'h5);
    for (int i = 1; i <= 16; i++) begin
      bus_op(1'b0, A_DATA, '0, 0, rd, c1);
      chk($sformatf("ovr_read%0d", i), rd, 32'(i));
    end
    bus_op(1'b0, A_STATUS, '0, 0, rd, c1);
    chk("ovr_status_drained", rd, 32'h4);
    bus_op(1'b1, A_STATUS, 32'h4, 0, rd, c1);
    bus_op(1'b0, A_STATUS, '0, 0, rd, c1);
    chk("ovr_cleared", rd, 32'h0);

    // Frame error and glitch
    send_frame(8'h3C, 1'b0);
    bus_op(1'b0, A_STATUS, '0, 0, rd, c1);
    chk("ferr_status", rd, 32'h8);
    bus_op(1'b0, A_DATA, '0, 0, rd, c1);
    chk("ferr_discard", rd, 32'hFFFF_FFFF);
    bus_op(1'b1, A_STATUS, 32'h8, 0, rd, c1);
    bus_op(1'b0, A_STATUS, '0, 0, rd, c1);
    chk("ferr_cleared", rd, 32'h0);
    rxd = 1'b0;
    tick(2);
    rxd = 1'b1;
    tick(3 * DIV);
    bus_op(1'b0, A_STATUS, '0, 0, rd, c1);
    chk("glitch_status", rd, 32'h0);

    // Register 3 and CTRL
    bus_op(1'b0, 2'd3, '0, 0, rd, c1);
    chk("reg3_read", rd, 32'h0);
`ifdef UART_LOOPBACK_EN
    bus_op(1'b1, A_CTRL, 32'h1, 0, rd, c1);
    bus_op(1'b0, A_CTRL, '0, 0, rd, c1);
    chk("ctrl_loopback", rd, 32'h1);
    bus_op(1'b1, A_DATA, 32'h5A, 0, rd, c1);
    tick(10 * DIV + 10);
    bus_op(1'b0, A_DATA, '0, 0, rd, c1);
    chk("loopback_data", rd, 32'h5A);
    bus_op(1'b1, A_CTRL, 32'h0, 0, rd, c1);
`else
    bus_op(1'b1, A_CTRL, 32'h1, 0, rd, c1);
    chk("ctrl_write_done", 32'(c1), 32'd1);
    bus_op(1'b0, A_CTRL, '0, 0, rd, c1);
    chk("ctrl_absent", rd, 32'h0);
`endif

    // Reset mid-frame
    bus_op(1'b1, A_DATA, 32'h00, 0, rd, c1);
    tick(30);
    chk("mid_frame_low", 32'(txd), 32'd0);
    resetn = 1'b0;
    tick(1);
    chk("mid_rst_txd", 32'(txd), 32'd1);
    chk("mid_rst_done", 32'(ctrl_done), 32'd0);
    chk("mid_rst_rdat", ctrl_rdat, 32'h0);
    tick(1);
    resetn = 1'b1;
    bus_op(1'b0, A_STATUS, '0, 0, rd, c1);
    chk("post_rst_status", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
